// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the segmented pipelined adder: default geometry,
// the stage-count helper and the stage-carry vector type.
package pipe_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  // Number of pipeline stages needed to cover a width-bit add in seg-bit slices.
  function automatic int seg_count(input int width, input int seg);
    return width / seg;
  endfunction

  // One carry bit per stage boundary for the default geometry.
  typedef logic [DEF_WIDTH/DEF_SEG-1:0] stage_carry_t;

endpackage

// File: rtl/seg_add_stage.sv
// One stage of the skewed adder pipeline. Stage IDX adds its own SEG-bit
// slice using the carry handed over by the previous stage. Slices above IDX
// pass through untouched as operand bits. Slices below IDX are already
// finished sum bits and are also passed through.
module seg_add_stage
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_s,
  input  logic             up_c,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] s_q,
  output logic             c_q
);

  logic [SEG:0]     seg_sum;
  logic [WIDTH-1:0] s_next;
  logic             load;

  // The register can take new data when it is empty or when its current
  // contents move on this cycle.
  assign up_ready = !valid || dn_ready;
  assign load     = up_ready && up_valid;

  // Slice add with carry-in, merged into the partially finished sum word.
  always_comb begin
    seg_sum = {1'b0, up_a[IDX*SEG +: SEG]} + {1'b0, up_b[IDX*SEG +: SEG]}
              + {{SEG{1'b0}}, up_c};
    s_next  = up_s;
    s_next[IDX*SEG +: SEG] = seg_sum[SEG-1:0];
  end

  // Stage register. A bubble from upstream is absorbed whenever the slot frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
    end else begin
      if (up_ready) valid <= up_valid;
      if (load) begin
        a_q <= up_a;
        b_q <= up_b;
        s_q <= s_next;
        c_q <= seg_sum[SEG];
      end
    end
  end

endmodule

// File: rtl/pipe_seg_adder.sv
// Pipelined WIDTH-bit adder built from WIDTH/SEG slice stages with a
// valid/ready stream on both sides. The last stage register drives the outputs
// directly.
// Optional: define PIPE_SEG_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_seg_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_SEG_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = seg_count(WIDTH, SEG);

  if ((WIDTH % SEG) != 0) begin : g_seg_check
    $error("pipe_seg_adder: WIDTH must be a multiple of SEG");
  end

  // Index 0 is the operand input; index k+1 is the register of stage k.
  logic [WIDTH-1:0] a_st [STAGES+1];
  logic [WIDTH-1:0] b_st [STAGES+1];
  logic [WIDTH-1:0] s_st [STAGES+1];
  logic [STAGES:0]  c_st;
  logic [STAGES:0]  v_st;

  assign a_st[0] = a;
  assign b_st[0] = b;
  assign s_st[0] = '0;
  assign c_st[0] = cin;
  assign v_st[0] = in_valid;

  // Ready flows backwards stage by stage, so each stage keeps its own ready
  // signal rather than sharing one vector across the chain.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic rdy;
    logic dn_rdy;

    if (k == STAGES-1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = g_stage[k+1].rdy;
    end

    seg_add_stage #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .IDX   (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v_st[k]),
      .up_ready (rdy),
      .up_a     (a_st[k]),
      .up_b     (b_st[k]),
      .up_s     (s_st[k]),
      .up_c     (c_st[k]),
      .dn_ready (dn_rdy),
      .valid    (v_st[k+1]),
      .a_q      (a_st[k+1]),
      .b_q      (b_st[k+1]),
      .s_q      (s_st[k+1]),
      .c_q      (c_st[k+1])
    );
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = v_st[STAGES];
  assign sum       = s_st[STAGES];
  assign cout      = c_st[STAGES];

`ifdef PIPE_SEG_ADDER_OVF_EN
  // Carry into the MSB is recovered from the held operand and sum bits, so ovf
  // is a pure function of the output register and holds with it.
  assign ovf = a_st[STAGES][WIDTH-1] ^ b_st[STAGES][WIDTH-1]
             ^ s_st[STAGES][WIDTH-1] ^ c_st[STAGES];
`endif

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Bench for pipe_seg_adder: directed scenarios plus a randomized stream,
// all checked against an arithmetic model queue.
module tb_pipe_seg_adder;

  localparam int W  = 32;
  localparam int SG = 8;
  localparam int ST = W / SG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         dut_ovf;

`ifdef PIPE_SEG_ADDER_OVF_EN
  logic ovf;
  assign dut_ovf = ovf;
`else
  assign dut_ovf = 1'b0;
`endif

  pipe_seg_adder #(.WIDTH(W), .SEG(SG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_SEG_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
    int           lat;
  } ent_t;

  ent_t mq[$];
  ent_t rx[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_acc = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_s = '0;
  logic         hold_c = 1'b0;
  logic         hold_o = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic ent_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input int t);
    ent_t e;
    logic [W:0] full;
    full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s   = full[W-1:0];
    e.c   = full[W];
    e.o   = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    e.t   = t;
    e.lat = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Compare process: inputs are stable at the falling edge, so accept and
  // transfer decisions made here are the ones the next rising edge performs.
  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      check("in_ready", in_ready, (mq.size() < ST) || out_ready);
      if (out_valid) check("valid_with_data", mq.size() > 0, 1);
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, hold_s);
        check("hold_cout", cout, hold_c);
        check("hold_ovf", dut_ovf, hold_o);
      end
      if (out_valid && out_ready && mq.size() > 0) begin
        e = mq.pop_front();
        check("sum", sum, e.s);
        check("cout", cout, e.c);
`ifdef PIPE_SEG_ADDER_OVF_EN
        check("ovf", dut_ovf, e.o);
`endif
        check("latency_min", (cyc - e.t) >= ST, 1);
        rx.push_back('{s: sum, c: cout, o: dut_ovf, t: cyc, lat: cyc - e.t});
      end
      hold_v = out_valid && !out_ready;
      hold_s = sum;
      hold_c = cout;
      hold_o = dut_ovf;
      if (in_valid && in_ready) begin
        mq.push_back(model(a, b, cin, cyc));
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int i = 0;
    while (rx.size() < n && i < budget) begin
      tick();
      i++;
    end
    check(name, rx.size(), n);
  endtask

  logic [W-1:0] va [4] = '{32'd1, 32'h8000_0000, 32'h1234_5678, 32'd0};
  logic [W-1:0] vb [4] = '{32'd2, 32'h8000_0000, 32'h0000_0001, 32'd0};
  logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] es [4] = '{32'd3, 32'd0, 32'h1234_567A, 32'd0};
  logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int acc0;
    int d;

    // Reset held for three cycles.
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ovf", dut_ovf, 0);
    tick();
    rst_n = 1'b1;

    // Full ripple across every segment.
    out_ready = 1'b1;
    rx.delete();
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_rx(1, 20, "ripple_count");
    if (rx.size() >= 1) begin
      check("ripple_latency", rx[0].lat, ST);
      check("ripple_sum", rx[0].s, 32'h0);
      check("ripple_cout", rx[0].c, 1);
    end

    // Four back-to-back accepts, four consecutive results.
    rx.delete();
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; cin = 1'b0;
    wait_rx(4, 20, "stream_count");
    if (rx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("stream_sum%0d", i), rx[i].s, es[i]);
        check($sformatf("stream_cout%0d", i), rx[i].c, ec[i]);
        check($sformatf("stream_cycle%0d", i), rx[i].t - rx[0].t, i);
      end
      check("stream_latency", rx[0].lat, ST);
    end

    // Backpressure: exactly ST accepts, then stall with the head result held.
    out_ready = 1'b0;
    acc0 = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; cin = 1'(($urandom) & 1);
      tick();
    end
    check("bp_accepts", n_acc - acc0, ST);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    in_valid = 1'b0;
    rx.delete();
    out_ready = 1'b1;
    wait_rx(ST, 20, "bp_drain_count");
    check("bp_model_empty", mq.size(), 0);

    // Alternating bubbles keep their spacing at the output.
    rx.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      a = pick(); b = pick(); cin = 1'(($urandom) & 1);
      tick();
    end
    in_valid = 1'b0;
    wait_rx(4, 20, "bubble_count");
    if (rx.size() == 4)
      for (int i = 1; i < 4; i++)
        check($sformatf("bubble_gap%0d", i), rx[i].t - rx[i-1].t, 2);

    // Reset with three operations in flight, asserted between clock edges.
    out_ready = 1'b0;
    rx.delete();
    for (int i = 0; i < 3; i++) begin
      a = 32'd10 + 32'(i); b = 32'd20; cin = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("pre_rst_out_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    mq.delete();
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    check("async_rst_in_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    check("post_rst_no_output", rx.size(), 0);
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; cin = 1'b0;
    wait_rx(1, 20, "post_rst_count");
    if (rx.size() >= 1) begin
      check("post_rst_latency", rx[0].lat, ST);
      check("post_rst_sum", rx[0].s, 32'h0000_0101);
    end

`ifdef PIPE_SEG_ADDER_OVF_EN
    // Signed overflow on the way up, none on a wrap through -1.
    rx.delete();
    a = 32'h7FFF_FFFF; b = 32'd1; in_valid = 1'b1;
    tick();
    a = 32'hFFFF_FFFF; b = 32'd1;
    tick();
    in_valid = 1'b0;
    wait_rx(2, 20, "ovf_count");
    if (rx.size() == 2) begin
      check("ovf0_sum", rx[0].s, 32'h8000_0000);
      check("ovf0_ovf", rx[0].o, 1);
      check("ovf0_cout", rx[0].c, 0);
      check("ovf1_ovf", rx[1].o, 0);
      check("ovf1_cout", rx[1].c, 1);
    end
`endif

    // Randomized stream with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = pick(); b = pick(); cin = 1'(($urandom) & 1);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    d = 0;
    while (mq.size() > 0 && d < 50) begin
      tick();
      d++;
    end
    check("final_drain", mq.size(), 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_seg_adder.md
Name: pipe_seg_adder

Overview:
- Parametrised, pipelined successor to the single-bit half/full adder cells.
- Splits a WIDTH-bit add into WIDTH/SEG segments. Each pipeline stage adds one segment and registers the carry into the next stage.
- Results stream out in order under a valid/ready handshake.
- Sits between operand sources and result consumers wherever a wide add would otherwise limit clock frequency.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- SEG, 8, segment width per stage. WIDTH % SEG must be 0, else $error at elaboration.
- STAGES, WIDTH/SEG, derived localparam and pipeline depth. Not overridable.

Ports:
- clk, input, 1, clock; rising edge active.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands present this cycle.
- in_ready, output, 1, block accepts operands this cycle.
- a, input, WIDTH, operand A (unsigned).
- b, input, WIDTH, operand B (unsigned).
- cin, input, 1, carry-in to segment 0.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts result.
- sum, output, WIDTH, a+b+cin modulo 2^WIDTH.
- cout, output, 1, carry out of MSB.
- ovf, output, 1, signed overflow; present only with OVF_EN.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-low.
  - On rst_n=0, every stage valid bit, data register and carry register clears to 0 immediately.
  - Reset values: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 (no stage holds valid data).
- Stage structure:
  - Stage k (0..STAGES-1) adds a[k*SEG +: SEG] + b[k*SEG +: SEG] + c_k. c_0 = cin; c_k = registered carry from stage k-1.
  - Segments above k travel unmodified as a/b bits. Segments below k travel as completed sum bits. This is a skewed pipeline.
  - The final stage register drives sum, cout and out_valid directly. No combinational path from a, b or cin to the outputs.
- Latency:
  - Exactly STAGES cycles from the accept edge (in_valid & in_ready) to out_valid=1, when there is no backpressure.
  - Throughput is 1 result per cycle.
- Handshake:
  - A stage advances when next_free_k = !valid_{k+1} | adv_{k+1}. The last stage uses !out_valid | out_ready.
  - in_ready = !valid_0 | adv_0. This is a combinational ready chain and bubbles collapse.
  - Accept happens when in_valid & in_ready. Result transfer happens when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
  - in_valid=0 inserts a bubble, which is never presented at the output.
- Ordering: strictly FIFO; no reordering and no dropping.
- Simultaneous events: accept and output transfer in the same cycle with the pipeline full are both permitted. The occupancy count stays unchanged.
- Wrap-around: the sum wraps modulo 2^WIDTH, and cout reports the carry.
- Reset mid-operation: all in-flight operations are discarded. The first post-reset result comes STAGES cycles after the first new accept.
- Boundary: with STAGES=1 (SEG=WIDTH) the block degenerates to a registered adder with latency 1.

Optional Feature:
- Macro: PIPE_SEG_ADDER_OVF_EN.
- Defined:
  - Port ovf exists. ovf = carry into bit WIDTH-1 XOR cout (two's-complement overflow).
  - ovf is registered alongside sum and is valid exactly when out_valid=1.
  - Its reset value is 0.
- Undefined: the port and all overflow logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_adder_pkg:
  - function seg_count(width, seg).
  - typedef for the stage-carry vector.
  - Default WIDTH/SEG constants.
- Sub-module seg_add_stage, instantiated STAGES times via generate. It contains:
  - the SEG-bit add with carry-in;
  - its valid/data/carry registers;
  - local advance logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> out_valid=0, sum=0, cout=0, in_ready=1. Assert rst_n=0 asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Full ripple (WIDTH=32, SEG=8): a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=32'h0000_0000, cout=1.
- Streaming: 4 back-to-back accepts (1+2, 32'h8000_0000+32'h8000_0000, 32'h1234_5678+32'h0000_0001 with cin=1, 0+0) with out_ready=1 -> results on 4 consecutive cycles, in order:
  - sum=3, cout=0;
  - sum=0, cout=1;
  - sum=32'h1234_567A, cout=0;
  - sum=0, cout=0.
- Backpressure: out_ready=0 with in_valid=1 continuously -> exactly 4 accepts, then in_ready=0 and the output holds the first result stable. Raise out_ready -> all 4 drain in order with no loss or duplication.
- Bubbles and reset mid-flight: alternate in_valid 1/0 -> out_valid alternates after 4 cycles. Pulse rst_n low with 3 ops in flight -> none emerge, and the next accepted op appears after 4 cycles.
- OVF_EN: a=32'h7FFF_FFFF, b=1 -> sum=32'h8000_0000, ovf=1, cout=0. Then a=32'hFFFF_FFFF, b=1 -> ovf=0, cout=1.
